// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : enc_pkg
//  Purpose : Shared definitions for the encoder emulator: default geometry,
//            quadrature state encoding (state value == {A,B}) and the
//            per-RPM phase-increment computation.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package enc_pkg;

  localparam int PPR_DEF   = 256;  // ticks per revolution
  localparam int RPM_W_DEF = 11;   // rpm command / readback width

  // Each state value is the {A,B} output pair, so the outputs are just the
  // state register bits.
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b11,
    S3 = 2'b10
  } quad_state_t;

  // K = round(ppr * 2**acc_w / (60 * clk_hz)), the phase increment per RPM.
  function automatic longint unsigned calc_k(
    input longint unsigned clk_hz,
    input longint unsigned ppr,
    input int unsigned     acc_w
  );
    longint unsigned num;
    longint unsigned den;
    num = ppr << acc_w;
    den = 60 * clk_hz;
    return (num + (den >> 1)) / den;
  endfunction

endpackage
`default_nettype wire

// File: rtl/enc_quad_fsm.sv
`default_nettype none
// ============================================================================
//  Module  : enc_quad_fsm
//  Purpose : Quadrature A/B generator and shaft position tracker. Advances one
//            quadrature state and one position count per step, direction
//            selected by dir. Outputs are registered and change on the same
//            clock edge that the parent registers its tick pulse.
//  Ports   : clk    in  system clock
//            rst    in  asynchronous reset, active-high
//            step   in  advance one count this clock
//            dir    in  0 = forward (S0->S1->S2->S3), 1 = reverse
//            quad_a out quadrature channel A
//            quad_b out quadrature channel B
//            index  out high while position == 0 (refreshed on each step)
//  Rev     : 1.0  initial release
// ============================================================================
module enc_quad_fsm
  import enc_pkg::*;
#(
  parameter int PPR = PPR_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic step,
  input  logic dir,
  output logic quad_a,
  output logic quad_b,
  output logic index
);

  localparam int               POS_W    = (PPR > 1) ? $clog2(PPR) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(PPR - 1);

  quad_state_t      state;
  quad_state_t      state_next;
  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] pos_next;

  always_comb begin
    state_next = state;
    pos_next   = pos;
    if (step) begin
      if (!dir) begin
        case (state)
          S0:      state_next = S1;
          S1:      state_next = S2;
          S2:      state_next = S3;
          default: state_next = S0;
        endcase
        pos_next = (pos == POS_LAST) ? '0 : pos + 1'b1;
      end else begin
        case (state)
          S0:      state_next = S3;
          S3:      state_next = S2;
          S2:      state_next = S1;
          default: state_next = S0;
        endcase
        pos_next = (pos == '0) ? POS_LAST : pos - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S0;
      pos   <= '0;
      index <= 1'b0;
    end else begin
      state <= state_next;
      pos   <= pos_next;
      // Index only refreshes with a step so it holds while frozen.
      if (step) begin
        index <= (pos_next == '0);
      end
    end
  end

  assign quad_a = state[1];
  assign quad_b = state[0];

endmodule
`default_nettype wire

// File: rtl/enc_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module  : enc_tick_gen
//  Purpose : Encoder emulator. Converts a commanded speed in RPM into encoder
//            tick pulses, quadrature A/B, an index pulse and a free-running
//            measurement-window gate strobe every CLK_HZ clocks.
//  Ports   : clk      in  system clock, rising edge
//            rst      in  asynchronous reset, active-high
//            enable   in  1 = run, 0 = freeze accumulator and outputs
//            dir      in  0 = forward, 1 = reverse
//            rpm_cmd  in  commanded speed (RPM_W bits)
//            rpm_load in  1-clk strobe latching rpm_cmd
//            rpm_cur  out applied (clamped) speed
//            tick     out 1-clk pulse per encoder count
//            quad_a   out quadrature channel A
//            quad_b   out quadrature channel B
//            index    out high while position == 0
//            gate     out 1-clk pulse every CLK_HZ clocks
//  Rev     : 1.0  initial release
// ============================================================================
module enc_tick_gen
  import enc_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int PPR     = PPR_DEF,
  parameter int RPM_W   = RPM_W_DEF,
  parameter int RPM_MAX = 2047,
  parameter int ACC_W   = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             dir,
  input  logic [RPM_W-1:0] rpm_cmd,
  input  logic             rpm_load,
  output logic [RPM_W-1:0] rpm_cur,
  output logic             tick,
  output logic             quad_a,
  output logic             quad_b,
  output logic             index,
  output logic             gate
);

  localparam logic [ACC_W-1:0]  K         = ACC_W'(calc_k(CLK_HZ, PPR, ACC_W));
  localparam int                GATE_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(CLK_HZ - 1);
  localparam logic [RPM_W-1:0]  RPM_CEIL  = RPM_W'(RPM_MAX);

  logic [RPM_W-1:0]  rpm_clamped;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  inc;
  logic [ACC_W:0]    sum;
  logic              step;
  logic [GATE_W-1:0] gate_cnt;

  assign rpm_clamped = (rpm_cmd > RPM_CEIL) ? RPM_CEIL : rpm_cmd;

  // The carry out of the phase accumulator is the tick. inc stays below
  // 2**ACC_W for every legal rpm, so at most one carry per clock.
  assign sum  = {1'b0, acc} + {1'b0, inc};
  assign step = enable & sum[ACC_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpm_cur  <= '0;
      inc      <= '0;
      acc      <= '0;
      tick     <= 1'b0;
      gate_cnt <= '0;
      gate     <= 1'b0;
    end else begin
      // Load is independent of enable; acc is kept so phase stays continuous.
      if (rpm_load) begin
        rpm_cur <= rpm_clamped;
        inc     <= ACC_W'(rpm_clamped) * K;
      end

      if (enable) begin
        acc  <= sum[ACC_W-1:0];
        tick <= sum[ACC_W];
      end else begin
        tick <= 1'b0;
      end

      // Measurement window runs regardless of enable.
      gate     <= (gate_cnt == GATE_LAST);
      gate_cnt <= (gate_cnt == GATE_LAST) ? '0 : gate_cnt + 1'b1;
    end
  end

  // The FSM registers A/B/index on the same edge that tick is registered.
  enc_quad_fsm #(
    .PPR (PPR)
  ) u_quad (
    .clk    (clk),
    .rst    (rst),
    .step   (step),
    .dir    (dir),
    .quad_a (quad_a),
    .quad_b (quad_b),
    .index  (index)
  );

endmodule
`default_nettype wire

// File: tb/tb_enc_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module  : tb_enc_tick_gen
//  Purpose : Self-checking bench for enc_tick_gen. Stimulus pushes expected
//            per-tick {A,B,index} codes and per-window tick counts into
//            queues; a monitor on the falling edge pops and compares them as
//            ticks and gate strobes appear. A second instance with
//            RPM_MAX=1500 exercises the clamp.
//            The window is 10_000 clocks; ticks per window equal rpm*PPR/60
//            independent of CLK_HZ, so the expected counts match a 1 s window.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_enc_tick_gen;

  localparam int CLK_HZ = 10_000;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        enable   = 1'b0;
  logic        dir      = 1'b0;
  logic        rpm_load = 1'b0;
  logic [10:0] rpm_cmd  = '0;

  logic [10:0] rpm_cur, rpm_cur2;
  logic        tick, quad_a, quad_b, index, gate;
  logic        tick2, quad_a2, quad_b2, index2, gate2;

  always #5 clk = ~clk;

  enc_tick_gen #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .rst(rst), .enable(enable), .dir(dir),
    .rpm_cmd(rpm_cmd), .rpm_load(rpm_load), .rpm_cur(rpm_cur),
    .tick(tick), .quad_a(quad_a), .quad_b(quad_b), .index(index), .gate(gate)
  );

  enc_tick_gen #(.CLK_HZ(CLK_HZ), .RPM_MAX(1500)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .dir(dir),
    .rpm_cmd(rpm_cmd), .rpm_load(rpm_load), .rpm_cur(rpm_cur2),
    .tick(tick2), .quad_a(quad_a2), .quad_b(quad_b2), .index(index2), .gate(gate2)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int id;
    int lo;  int hi;    // dut ticks per window
    int rlo; int rhi;   // dut readback rpm = ticks*60/256
    int lo2; int hi2;   // dut2 ticks per window
  } win_t;

  win_t       win_q[$];
  logic [2:0] ab_q[$];   // {A,B,index} expected at each dut tick

  // Hand-derived AB codes indexed by (tick number mod 4) from S0.
  logic [1:0] fwd_ab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [1:0] rev_ab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- monitor ----------------
  int         gap   = 0;
  int         wcnt  = 0;
  int         wcnt2 = 0;
  logic [2:0] e_ab;
  win_t       w;

  always @(negedge clk) begin
    if (rst) begin
      gap = 0; wcnt = 0; wcnt2 = 0;
    end else begin
      gap++;
      if (tick)  wcnt++;
      if (tick2) wcnt2++;
      if (tick && ab_q.size() > 0) begin
        e_ab = ab_q.pop_front();
        check("ab_index", int'({quad_a, quad_b, index}), int'(e_ab));
      end
      if (gate) begin
        check("gate_period", gap, CLK_HZ);
        check("gate2_align", int'(gate2), 1);
        gap = 0;
        if (win_q.size() > 0) begin
          w = win_q.pop_front();
          check_rng($sformatf("win%0d_ticks", w.id), wcnt, w.lo, w.hi);
          check_rng($sformatf("win%0d_readback", w.id), wcnt * 60 / 256, w.rlo, w.rhi);
          check_rng($sformatf("win%0d_ticks_clamp", w.id), wcnt2, w.lo2, w.hi2);
        end
        wcnt = 0; wcnt2 = 0;
      end
    end
  end

  // ---------------- stimulus helpers (entered/left at posedge+1) ----------------
  task automatic wait_gate(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!gate && n < CLK_HZ + 20);
    if (!gate) begin
      n_checks++; n_errors++;
      $display("FAIL %s: no gate within %0d clocks, expected one", tag, n);
    end
  endtask

  task automatic wait_ab(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (ab_q.size() > target && n < budget) begin
      @(posedge clk); #1; n++;
    end
    if (ab_q.size() > target) begin
      n_checks++; n_errors++;
      $display("FAIL %s: %0d codes pending, expected %0d", tag, ab_q.size(), target);
    end
  endtask

  task automatic do_load(input logic [10:0] v);
    rpm_cmd  = v;
    rpm_load = 1'b1;
    @(posedge clk); #1;
    rpm_load = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Window result becomes due one cycle after the gate just seen, so the
  // monitor applies it to the next full window.
  task automatic measure(input win_t e);
    wait_gate("pre_window");
    @(posedge clk); #1;
    win_q.push_back(e);
    wait_gate("window");
    @(posedge clk); #1;
  endtask

  int tk;

  initial begin
    // ---- reset values ----
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", int'({tick, quad_a, quad_b, index, gate}), 0);
    check("reset_rpm", int'(rpm_cur), 0);
    @(negedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // ---- 1: async reset mid-run at 600 rpm ----
    enable = 1'b1; dir = 1'b0;
    do_load(11'd600);
    check("load_600", int'(rpm_cur), 600);
    repeat (200) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun_reset_outs", int'({tick, quad_a, quad_b, index, gate}), 0);
    check("midrun_reset_rpm", int'(rpm_cur), 0);
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_load(11'd600);

    // ---- 2: one clean window at 600 rpm (first gate period checked by monitor) ----
    measure('{2, 2559, 2561, 599, 600, 2559, 2561});

    // ---- 3: quadrature sequence and index, forward then reverse ----
    do_reset();
    dir = 1'b0;
    for (int k = 1; k <= 256; k++)
      ab_q.push_back({fwd_ab[k % 4], (k % 256) == 0});
    do_load(11'd600);
    wait_ab(0, 2000, "fwd_drain");
    dir = 1'b1;
    for (int k = 1; k <= 264; k++)
      ab_q.push_back({rev_ab[k % 4], (k % 256) == 0});

    // ---- 5: freeze after reverse tick 259, then resume ----
    wait_ab(5, 2500, "rev_drain");
    enable = 1'b0;
    tk = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (tick) tk++;
    end
    check("frozen_ticks", tk, 0);
    check("frozen_ab_index", int'({quad_a, quad_b, index}), int'(3'b010));
    check("frozen_pending", ab_q.size(), 5);
    enable = 1'b1;
    wait_ab(0, 200, "resume_drain");

    // ---- 4: clamp and width truncation ----
    do_load(11'd2047);
    check("load_2047", int'(rpm_cur), 2047);
    check("clamp_2047", int'(rpm_cur2), 1500);
    do_load(11'(3000));
    check("load_3000_trunc", int'(rpm_cur), 952);
    check("clamp_3000_trunc", int'(rpm_cur2), 952);
    do_load(11'd2000);
    check("load_2000", int'(rpm_cur), 2000);
    check("clamp_2000", int'(rpm_cur2), 1500);
    measure('{4, 8532, 8534, 1999, 2000, 6399, 6401});

    // ---- 6: zero speed, gate keeps running ----
    do_load(11'd0);
    check("load_0", int'(rpm_cur), 0);
    measure('{6, 0, 0, 0, 0, 0, 0});
    check("windows_consumed", win_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
